// File: rtl/sumador_pkg.sv
// sumador_pkg
// Shared types and constants for the 8-bit adder tile sequencer.
//   state_t     : sequencer FSM states
//   SUM_WIDTH   : default operand / sum width
//   CARRY_CNT_W : default width of the saturating carry-event counter
package sumador_pkg;

   localparam int SUM_WIDTH   = 8;
   localparam int CARRY_CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_B = 2'd1,
      S_ADD    = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

endpackage

// File: rtl/sumador8_core.sv
// sumador8_core
// Purely combinational unsigned adder; no clock, no state.
// Ports:
//   a, b  : WIDTH-bit operands
//   sum   : (a + b) modulo 2^WIDTH
//   carry : bit WIDTH of the full-width sum
module sumador8_core
   import sumador_pkg::*;
#(
   parameter int WIDTH = SUM_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] full_sum;

   // Zero-extend both operands so the carry lands in the extra top bit.
   assign full_sum     = {1'b0, a} + {1'b0, b};
   assign {carry, sum} = full_sum;

endmodule

// File: rtl/sumador_seq_ctrl.sv
// sumador_seq_ctrl
// Collects two operands serially over a valid/ready byte bus, adds them
// through sumador8_core, registers the result and holds it until the
// consumer acknowledges it. Counts (saturating) how many adds carried.
// Ports:
//   clk, rst        : clock (rising edge), async active-high reset
//   enable          : gates operand acceptance only
//   data_in         : operand byte
//   data_valid      : data_in is valid
//   data_ready      : operand can be accepted this cycle (combinational)
//   sum_out         : registered sum of the last add
//   carry_out       : registered carry of the last add
//   result_valid    : sum_out/carry_out hold an unacknowledged result
//   result_ack      : consumer takes the result
//   busy            : FSM is not idle
//   carry_cnt       : saturating count of adds that carried
module sumador_seq_ctrl
   import sumador_pkg::*;
#(
   parameter int WIDTH = SUM_WIDTH,
   parameter int CNT_W = CARRY_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             result_valid,
   input  logic             result_ack,
   output logic             busy,
   output logic [CNT_W-1:0] carry_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] core_sum;
   logic             core_carry;
   logic             accept;

   sumador8_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (op_a),
      .b     (op_b),
      .sum   (core_sum),
      .carry (core_carry)
   );

   // Ready only in the two operand-collecting states, and held low during
   // reset so nothing upstream sees a handshake while the block is cleared.
   assign data_ready = !rst && enable && ((state == S_IDLE) || (state == S_LOAD_B));
   assign accept     = data_valid && data_ready;

   // Sequencer: collect A, collect B, add, then hold until acked.
   // The result registers change only in S_ADD so the last result survives
   // the ack. busy is registered alongside the state it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         op_a         <= '0;
         op_b         <= '0;
         sum_out      <= '0;
         carry_out    <= 1'b0;
         result_valid <= 1'b0;
         carry_cnt    <= '0;
         busy         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_a  <= data_in;
                  state <= S_LOAD_B;
                  busy  <= 1'b1;
               end
            end
            S_LOAD_B: begin
               if (accept) begin
                  op_b  <= data_in;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               sum_out      <= core_sum;
               carry_out    <= core_carry;
               result_valid <= 1'b1;
               if (core_carry && (carry_cnt != CNT_MAX)) begin
                  carry_cnt <= carry_cnt + 1'b1;
               end
               state <= S_HOLD;
            end
            S_HOLD: begin
               if (result_ack && result_valid) begin
                  result_valid <= 1'b0;
                  state        <= S_IDLE;
                  busy         <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sumador_seq_ctrl.sv
// tb_sumador_seq_ctrl
// Directed self-checking bench for sumador_seq_ctrl. Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_sumador_seq_ctrl;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   logic [7:0] sum_out;
   logic       carry_out;
   logic       result_valid;
   logic       result_ack;
   logic       busy;
   logic [3:0] carry_cnt;

   int checks   = 0;
   int failures = 0;

   sumador_seq_ctrl #(
      .WIDTH (8),
      .CNT_W (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .data_in      (data_in),
      .data_valid   (data_valid),
      .data_ready   (data_ready),
      .sum_out      (sum_out),
      .carry_out    (carry_out),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .busy         (busy),
      .carry_cnt    (carry_cnt)
   );

   // 10 ns clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison passes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance to 1 ns after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one byte, confirm the block is ready for it, and let it transfer.
   task automatic applyStimulus(input string tag, input logic [7:0] value);
      data_in    = value;
      data_valid = 1'b1;
      #0;
      checkOutput({tag, "_ready"}, {31'd0, data_ready}, 32'd1);
      step();
      data_valid = 1'b0;
   endtask

   // Full operation: A, B, add, ack, with hand-computed expectations.
   task automatic runAdd(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_sum, input logic exp_carry,
                         input logic [3:0] exp_cnt);
      applyStimulus({tag, "_a"}, a);
      applyStimulus({tag, "_b"}, b);
      // One edge after B is taken the FSM is in S_ADD: no result yet.
      checkOutput({tag, "_rv_pre"}, {31'd0, result_valid}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      step();
      checkOutput({tag, "_rv"}, {31'd0, result_valid}, 32'd1);
      checkOutput({tag, "_sum"}, {24'd0, sum_out}, {24'd0, exp_sum});
      checkOutput({tag, "_carry"}, {31'd0, carry_out}, {31'd0, exp_carry});
      checkOutput({tag, "_cnt"}, {28'd0, carry_cnt}, {28'd0, exp_cnt});
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      checkOutput({tag, "_rv_ack"}, {31'd0, result_valid}, 32'd0);
      checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_sum_kept"}, {24'd0, sum_out}, {24'd0, exp_sum});
   endtask

   // Check every output reads its reset value.
   task automatic checkResetState(input string tag);
      checkOutput({tag, "_sum"}, {24'd0, sum_out}, 32'd0);
      checkOutput({tag, "_carry"}, {31'd0, carry_out}, 32'd0);
      checkOutput({tag, "_rv"}, {31'd0, result_valid}, 32'd0);
      checkOutput({tag, "_cnt"}, {28'd0, carry_cnt}, 32'd0);
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
      checkOutput({tag, "_ready"}, {31'd0, data_ready}, 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      enable     = 1'b0;
      data_in    = 8'h00;
      data_valid = 1'b0;
      result_ack = 1'b0;

      #3;
      checkResetState("por");
      #4;
      rst    = 1'b0;
      enable = 1'b1;
      step();

      // Reset in the middle of an operation, after A = 0x55.
      applyStimulus("rst_a", 8'h55);
      checkOutput("rst_busy_pre", {31'd0, busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkResetState("rst_mid");
      #1;
      rst = 1'b0;
      #0;
      checkOutput("rst_ready_after", {31'd0, data_ready}, 32'd1);
      step();

      // Plain add; the next byte must load as A, not B.
      runAdd("plain", 8'h25, 8'h13, 8'h38, 1'b0, 4'd0);

      // Carry wrap.
      runAdd("wrap", 8'hFF, 8'h01, 8'h00, 1'b1, 4'd1);

      // Backpressure: 0x0F + 0x0E = 0x1D, held for 10 cycles while the
      // upstream keeps offering toggling data.
      applyStimulus("bp_a", 8'h0F);
      applyStimulus("bp_b", 8'h0E);
      step();
      for (int i = 0; i < 10; i++) begin
         data_valid = 1'b1;
         data_in    = (i % 2 == 0) ? 8'hAA : 8'h55;
         #0;
         checkOutput("bp_ready", {31'd0, data_ready}, 32'd0);
         checkOutput("bp_rv", {31'd0, result_valid}, 32'd1);
         checkOutput("bp_sum", {24'd0, sum_out}, 32'h1D);
         checkOutput("bp_carry", {31'd0, carry_out}, 32'd0);
         step();
      end
      data_valid = 1'b0;
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      checkOutput("bp_rv_ack", {31'd0, result_valid}, 32'd0);
      checkOutput("bp_idle", {31'd0, busy}, 32'd0);
      checkOutput("bp_sum_kept", {24'd0, sum_out}, 32'h1D);
      checkOutput("bp_cnt", {28'd0, carry_cnt}, 32'd1);

      // Enable gating in S_IDLE.
      enable     = 1'b0;
      data_valid = 1'b1;
      data_in    = 8'h11;
      for (int i = 0; i < 5; i++) begin
         #0;
         checkOutput("en_ready", {31'd0, data_ready}, 32'd0);
         checkOutput("en_busy", {31'd0, busy}, 32'd0);
         step();
      end
      enable = 1'b1;
      step();
      data_valid = 1'b0;
      checkOutput("en_accept_busy", {31'd0, busy}, 32'd1);
      applyStimulus("en_b", 8'h22);
      step();
      checkOutput("en_sum", {24'd0, sum_out}, 32'h33);
      checkOutput("en_rv", {31'd0, result_valid}, 32'd1);
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;

      // Saturation from a freshly cleared counter.
      rst = 1'b1;
      #1;
      checkOutput("sat_rst_cnt", {28'd0, carry_cnt}, 32'd0);
      rst = 1'b0;
      step();
      for (int i = 1; i <= 17; i++) begin
         runAdd("sat", 8'h80, 8'h80, 8'h00, 1'b1, (i > 15) ? 4'd15 : 4'(i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net so the run always ends on its own.
   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL timeout: got running, expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
